valu_seq: RTL
=============

VALU_SEQ -- requirements
Module: valu_seq

Interface
REQ-001 Parameter VLEN, default 128, vector register width in bits; legal values are powers of two, 128 or more.
REQ-002 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 i_rst  in  1  synchronous, active-high reset.
REQ-004 i_valid  in  1 / o_ready  out  1  instruction handshake; transfer occurs when both are 1 at a rising edge.
REQ-005 i_ctrl  in  6  ALU op code, passed unchanged to o_alu_ctrl / i_sew  in  3  element width code (0=8 bit, 1=16, 2=32, 3=64, 4=128).
REQ-006 i_vl  in  8  element count / i_vs1, i_vs2, i_vd  in  5 each  register-group base indices.
REQ-007 i_vx  in  1  vector-scalar select / i_scalar  in  64  scalar operand.
REQ-008 o_vrf_raddr_a, o_vrf_raddr_b  out  5  register-file read addresses / i_vrf_rdata_a, i_vrf_rdata_b  in  VLEN  read data, valid one cycle after the address.
REQ-009 o_vrf_we  out  1, o_vrf_waddr  out  5, o_vrf_wdata  out  VLEN, o_vrf_wbe  out  VLEN/8  register-file write port with per-byte enable.
REQ-010 o_alu_sew  out  3, o_alu_ctrl  out  6, o_alu_a, o_alu_b  out  VLEN  drive the combinational vector ALU / i_alu_result  in  VLEN  ALU result in the same cycle.
REQ-011 o_done  out  1  one-cycle completion pulse / o_err  out  1  one-cycle illegal-instruction pulse, coincident with o_done.

Function
REQ-012 Each instruction is latched on handshake; inputs are ignored at all other times.
REQ-013 The FSM has five states: IDLE, READ, EXEC, WB and DONE; o_ready is 1 only in IDLE.
REQ-014 IDLE on accept goes to DONE with o_err=1 when i_sew>4 or 8<<i_sew>VLEN; otherwise to DONE when i_vl=0, else to READ with k=0.
REQ-015 Effective vl = min(i_vl, VLMAX), where VLMAX = 8*VLEN/SEW; the register count is N = ceil(vl*SEW/VLEN), from 1 to 8.
REQ-016 READ drives raddr_a=(vs2+k) mod 32 and raddr_b=(vs1+k) mod 32, then goes to EXEC; these addresses are held through EXEC.
REQ-017 EXEC drives o_alu_a=rdata_a and o_alu_b=rdata_b; when i_vx=1, o_alu_b is instead i_scalar truncated to SEW (sign-extended for SEW=128) and replicated across every element.
REQ-018 EXEC registers i_alu_result and the byte enables, then goes to WB.
REQ-019 Byte j of register k is enabled iff k*VLEN/8+j < vl*SEW/8.
REQ-020 WB asserts o_vrf_we for exactly one cycle with waddr=(vd+k) mod 32; then, if k=N-1, it goes to DONE, else it increments k and goes to READ.
REQ-021 DONE asserts o_done for one cycle, then goes to IDLE.
REQ-022 Latency: for an instruction accepted at edge 0, the WB for register k falls in cycle 3k+3, o_done falls in cycle 3N+1, and o_ready returns in cycle 3N+2.
REQ-023 When vl=0 or the instruction is illegal, o_done falls in cycle 1 and no write occurs.
REQ-024 Outside EXEC, o_alu_a, o_alu_b, o_alu_ctrl and o_alu_sew hold their last driven values.
REQ-025 Outside WB, o_vrf_we is 0.
REQ-026 Overlap of the source and destination groups is permitted; register k is read before it is written, and no hazard check is performed.

Reset
REQ-027 On i_rst=1 at a rising edge, the FSM enters IDLE and k is cleared.
REQ-028 While i_rst=1 and after reset: o_ready=1, o_vrf_we=0, o_done=0, o_err=0, and all address, data, byte-enable and ALU outputs are 0.
REQ-029 A reset mid-instruction abandons it: no further write, no o_done; a write already performed is not undone.

Configuration
REQ-030 Macro VALU_SEQ_TAIL_ONES_EN selects the tail policy for disabled bytes.
REQ-031 With VALU_SEQ_TAIL_ONES_EN defined: disabled bytes of o_vrf_wdata are 0xFF and o_vrf_wbe is all ones during WB (tail-agnostic).
REQ-032 Without VALU_SEQ_TAIL_ONES_EN: disabled bytes have their wbe bit at 0, leaving them undisturbed.

Verification
REQ-033 VLEN=128, sew=2, vl=4, VADD (0x00), vs2=1, vs1=2, vd=3, v1 lanes=1, v2 lanes=10 -> one write, waddr=3, lanes=11, wbe=0xFFFF, o_done in cycle 4.
REQ-034 sew=0, vl=20, VSUB vx, i_scalar=0x05, v4/v5 bytes=0x09 -> writes to vd, vd+1; the second write has wbe=0x000F with low 4 bytes 0x04 (without the macro); o_done in cycle 7.
REQ-035 sew=3, vl=200 -> clamped to vl=16, eight writes with waddr vd..vd+7, vd=30 wrapping to 0..5, all wbe=0xFFFF.
REQ-036 sew=5, or vl=0 -> o_done and o_err (o_err only for sew=5) in cycle 1, o_vrf_we never asserted, o_ready=1 in cycle 2.
REQ-037 i_rst asserted during the second READ of a 2-register instruction -> exactly one write is observed, no o_done, o_ready=1 on the next cycle.
REQ-038 With VALU_SEQ_TAIL_ONES_EN, the REQ-034 stimulus -> the second write has wbe=0xFFFF and bytes 4-15 = 0xFF.

Source files
------------

// File: rtl/valu_seq.sv
// valu_seq: vector ALU sequencer; macro VALU_SEQ_TAIL_ONES_EN selects the tail-agnostic (all-ones) tail policy
module valu_seq #(
    parameter int VLEN = 128
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [5:0]        i_ctrl,
    input  logic [2:0]        i_sew,
    input  logic [7:0]        i_vl,
    input  logic [4:0]        i_vs1,
    input  logic [4:0]        i_vs2,
    input  logic [4:0]        i_vd,
    input  logic              i_vx,
    input  logic [63:0]       i_scalar,
    output logic [4:0]        o_vrf_raddr_a,
    output logic [4:0]        o_vrf_raddr_b,
    input  logic [VLEN-1:0]   i_vrf_rdata_a,
    input  logic [VLEN-1:0]   i_vrf_rdata_b,
    output logic              o_vrf_we,
    output logic [4:0]        o_vrf_waddr,
    output logic [VLEN-1:0]   o_vrf_wdata,
    output logic [VLEN/8-1:0] o_vrf_wbe,
    output logic [2:0]        o_alu_sew,
    output logic [5:0]        o_alu_ctrl,
    output logic [VLEN-1:0]   o_alu_a,
    output logic [VLEN-1:0]   o_alu_b,
    input  logic [VLEN-1:0]   i_alu_result,
    output logic              o_done,
    output logic              o_err
);
    localparam int NB = VLEN / 8;
    localparam logic [2:0] S_IDLE = 3'd0, S_READ = 3'd1, S_EXEC = 3'd2, S_WB = 3'd3, S_DONE = 3'd4;
`ifdef VALU_SEQ_TAIL_ONES_EN
    localparam logic TAIL_ONES = 1'b1;
`else
    localparam logic TAIL_ONES = 1'b0;
`endif

    logic [2:0]      state_q, state_d, k_q, k_d, sew_q, alu_sew_q;
    logic [5:0]      ctrl_q, alu_ctrl_q;
    logic [4:0]      vs1_q, vs2_q, vd_q;
    logic            vx_q, err_q, legal, exec, en;
    logic [63:0]     scalar_q;
    logic [31:0]     nbytes_q, vlmax, vl_eff, nbytes;
    logic [3:0]      nreg_q, nreg;
    logic [127:0]    scalar_ext;
    logic [VLEN-1:0] alu_a_q, alu_b_q, wdata_q, wdata_d, scalar_rep;
    logic [NB-1:0]   wbe_q, wbe_d;

    assign exec          = state_q == S_EXEC;
    assign o_ready       = state_q == S_IDLE;
    assign o_vrf_we      = state_q == S_WB;
    assign o_done        = state_q == S_DONE;
    assign o_err         = o_done & err_q;
    assign o_vrf_raddr_a = vs2_q + 5'(k_q);
    assign o_vrf_raddr_b = vs1_q + 5'(k_q);
    assign o_vrf_waddr   = vd_q + 5'(k_q);
    assign o_vrf_wdata   = wdata_q;
    assign o_vrf_wbe     = wbe_q;
    assign o_alu_a       = exec ? i_vrf_rdata_a : alu_a_q;
    assign o_alu_b       = exec ? (vx_q ? scalar_rep : i_vrf_rdata_b) : alu_b_q;
    assign o_alu_ctrl    = exec ? ctrl_q : alu_ctrl_q;
    assign o_alu_sew     = exec ? sew_q : alu_sew_q;

    // Decode legality, clamped vl, active byte count and register count of the offered instruction
    always_comb begin
        legal  = (i_sew <= 3'd4) && ((32'd8 << i_sew) <= 32'(VLEN));
        vlmax  = 32'(VLEN) >> i_sew;
        vl_eff = (32'(i_vl) < vlmax) ? 32'(i_vl) : vlmax;
        nbytes = vl_eff << i_sew;
        nreg   = 4'((nbytes + 32'(NB - 1)) / 32'(NB));
    end

    // Replicate the SEW-truncated scalar (sign-extended at SEW=128) across every element
    always_comb begin
        scalar_ext = {{64{scalar_q[63]}}, scalar_q};
        scalar_rep = '0;
        for (int j = 0; j < NB; j++)
            scalar_rep[8*j +: 8] = scalar_ext[8*(j & ((1 << sew_q) - 1) & 15) +: 8];
    end

    // Byte enables and tail fill for register k, derived from its global byte offset
    always_comb begin
        wbe_d   = '0;
        wdata_d = '0;
        en      = 1'b0;
        for (int j = 0; j < NB; j++) begin
            en                 = (32'(k_q) * 32'(NB) + 32'(j)) < nbytes_q;
            wbe_d[j]           = en | TAIL_ONES;
            wdata_d[8*j +: 8]  = (TAIL_ONES && !en) ? 8'hFF : i_alu_result[8*j +: 8];
        end
    end

    // Sequencer next state: read, execute, write back once per register of the group
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: if (i_valid) begin
                state_d = (!legal || i_vl == 8'd0) ? S_DONE : S_READ;
                k_d     = '0;
            end
            S_READ: state_d = S_EXEC;
            S_EXEC: state_d = S_WB;
            S_WB: if (4'(k_q) == nreg_q - 4'd1) state_d = S_DONE;
                  else begin
                      k_d     = k_q + 3'd1;
                      state_d = S_READ;
                  end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, instruction latch on handshake, and ALU/write-back registers captured in EXEC
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            ctrl_q     <= '0;
            sew_q      <= '0;
            vs1_q      <= '0;
            vs2_q      <= '0;
            vd_q       <= '0;
            vx_q       <= 1'b0;
            err_q      <= 1'b0;
            scalar_q   <= '0;
            nbytes_q   <= '0;
            nreg_q     <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= '0;
            alu_sew_q  <= '0;
            wdata_q    <= '0;
            wbe_q      <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (o_ready && i_valid) begin
                ctrl_q   <= i_ctrl;
                sew_q    <= i_sew;
                vs1_q    <= i_vs1;
                vs2_q    <= i_vs2;
                vd_q     <= i_vd;
                vx_q     <= i_vx;
                scalar_q <= i_scalar;
                err_q    <= !legal;
                nbytes_q <= nbytes;
                nreg_q   <= nreg;
            end
            if (exec) begin
                alu_a_q    <= o_alu_a;
                alu_b_q    <= o_alu_b;
                alu_ctrl_q <= ctrl_q;
                alu_sew_q  <= sew_q;
                wdata_q    <= wdata_d;
                wbe_q      <= wbe_d;
            end
        end
    end
endmodule
